// File: rtl/cgra_adder_pe_pkg.sv
// -----------------------------------------------------------------------------
// cgra_pkg
// Shared definitions for the CGRA adder processing element:
//   CGRA_OP_W   - width of the operation select field
//   cgra_op_e   - operation encoding (ADD, SUB, accumulate, clear)
//   add_ovf     - signed overflow rule for an addition, from sign bits
//   sub_ovf     - signed overflow rule for a subtraction, from sign bits
// -----------------------------------------------------------------------------
package cgra_pkg;

    localparam int CGRA_OP_W = 2;

    typedef enum logic [CGRA_OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } cgra_op_e;

    // Addition overflows when both operands share a sign the result lacks.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

    // Subtraction overflows when operand signs differ and the result sign
    // differs from the minuend.
    function automatic logic sub_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_r);
        return (sign_a != sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/cgra_pipe_stage.sv
// -----------------------------------------------------------------------------
// cgra_pipe_stage
// One stallable pipeline register: a valid bit plus a payload word, loaded
// whenever the pipeline advances and held otherwise. Bubbles are carried like
// beats so the whole pipeline keeps its shape under stall.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   en                    - pipeline advance
//   in_valid, in_payload  - previous stage
//   out_valid, out_payload- registered stage contents
// -----------------------------------------------------------------------------
module cgra_pipe_stage #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    output logic [W-1:0] out_payload
);

    // Stage register: clear on reset, load on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
        end else if (en) begin
            out_valid   <= in_valid;
            out_payload <= in_payload;
        end
    end

endmodule

// File: rtl/cgra_adder_pe.sv
// -----------------------------------------------------------------------------
// cgra_adder_pe
// Pipelined adder processing element for the CGRA tile datapath. Performs
// ADD, SUB, accumulate (ACC) and accumulator clear (CLR) with carry/borrow and
// signed-overflow flags, behind a valid/ready handshake on both sides.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   on_off            - PE enable; low blocks new accepts, pipeline still drains
//   op                - operation (cgra_op_e), sampled with the operands
//   in_valid/in_ready - operand handshake; in_ready depends only on on_off,
//                       out_valid and out_ready
//   a, b              - operands (b unused for ACC and CLR)
//   out_valid/out_ready - result handshake
//   c, carry_out, overflow - registered result and flags
//   busy              - any beat in flight
// Parameters:
//   WIDTH   - operand/result width (>= 2)
//   LATENCY - accept-to-result depth in cycles (1..4)
// -----------------------------------------------------------------------------
module cgra_adder_pe
    import cgra_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 on_off,
    input  logic [CGRA_OP_W-1:0] op,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     c,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 busy
);

    // Payload layout: {overflow, carry_out, c}
    localparam int PW = WIDTH + 2;

    logic             advance_s;
    logic             accept_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             acc_we_s;
    logic [WIDTH-1:0] acc_r;
    logic             s1_valid_r;
    logic [PW-1:0]    s1_payload_r;
    logic             busy_s;

    logic             stg_valid_s   [LATENCY];
    logic [PW-1:0]    stg_payload_s [LATENCY];

    // The whole pipeline moves as one: it advances whenever the output slot
    // is empty or being consumed, bubbles included.
    assign advance_s = ~out_valid | out_ready;
    assign in_ready  = on_off & advance_s;
    assign accept_s  = in_valid & in_ready;

    // Operation datapath; the accumulator write is only committed on accept.
    always_comb begin
        sum_s      = '0;
        res_s      = '0;
        carry_s    = 1'b0;
        ovf_s      = 1'b0;
        acc_next_s = acc_r;
        acc_we_s   = 1'b0;
        case (cgra_op_e'(op))
            OP_ADD: begin
                sum_s   = {1'b0, a} + {1'b0, b};
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of a WIDTH+1 wide difference is the borrow.
                sum_s   = {1'b0, a} - {1'b0, b};
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = sub_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_ACC: begin
                sum_s      = {1'b0, acc_r} + {1'b0, a};
                res_s      = sum_s[WIDTH-1:0];
                carry_s    = sum_s[WIDTH];
                ovf_s      = add_ovf(acc_r[WIDTH-1], a[WIDTH-1], sum_s[WIDTH-1]);
                acc_next_s = sum_s[WIDTH-1:0];
                acc_we_s   = 1'b1;
            end
            OP_CLR: begin
                acc_next_s = '0;
                acc_we_s   = 1'b1;
            end
            default: begin
                acc_next_s = acc_r;
                acc_we_s   = 1'b0;
            end
        endcase
    end

    // Compute stage and accumulator; an advance without accept inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r   <= 1'b0;
            s1_payload_r <= '0;
            acc_r        <= '0;
        end else begin
            if (advance_s) begin
                s1_valid_r <= accept_s;
                if (accept_s) begin
                    s1_payload_r <= {ovf_s, carry_s, res_s};
                end
            end
            if (accept_s && acc_we_s) begin
                acc_r <= acc_next_s;
            end
        end
    end

    assign stg_valid_s[0]   = s1_valid_r;
    assign stg_payload_s[0] = s1_payload_r;

    // Pure delay stages 2..LATENCY.
    for (genvar g = 1; g < LATENCY; g++) begin : g_delay
        cgra_pipe_stage #(
            .W (PW)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .en          (advance_s),
            .in_valid    (stg_valid_s[g-1]),
            .in_payload  (stg_payload_s[g-1]),
            .out_valid   (stg_valid_s[g]),
            .out_payload (stg_payload_s[g])
        );
    end

    // Busy when any stage holds a live beat.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy_s = busy_s | stg_valid_s[i];
        end
    end

    assign busy      = busy_s;
    assign out_valid = stg_valid_s[LATENCY-1];
    assign c         = stg_payload_s[LATENCY-1][WIDTH-1:0];
    assign carry_out = stg_payload_s[LATENCY-1][WIDTH];
    assign overflow  = stg_payload_s[LATENCY-1][WIDTH+1];

endmodule
